dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester controller sharing the single-ported byte-lane data memory. Requester 0 is the CPU load/store unit; requester 1 is the debug/loader port.
- Arbitrates round-robin and sequences each access through a small FSM.
- Converts size/offset into the memory's 4-bit byte-write mask and replicated write data.
- Extracts and sign/zero-extends load data, then returns it with a one-cycle ack pulse.

Parameters:
- ADDR_W, 32, width of requester and memory addresses
- RR_INIT, 1, reset value of last_grant (1 gives requester 0 first win)

Ports:
- clk  in  1  system clock, all state on posedge
- reset  in  1  asynchronous, active-high reset
- mN_req  in  1  request level, N=0,1; held with fields stable until mN_ack
- mN_wr  in  1  1 = store, 0 = load
- mN_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- mN_unsigned  in  1  load zero-extend (1) / sign-extend (0)
- mN_addr  in  ADDR_W  byte address
- mN_wdata  in  32  store data, right-justified
- mN_ack  out  1  one-cycle completion pulse
- mN_rdata  out  32  load result, valid while mN_ack=1
- mN_err  out  1  access fault, valid while mN_ack=1
- daddr  out  ADDR_W  memory address
- dwdata  out  32  memory write data
- we  out  4  memory byte-write enables
- drdata  in  32  memory read data (combinational)

Behaviour:
- Reset (async, any state): state=IDLE, last_grant=RR_INIT, latched request cleared. All outputs are 0: acks, rdata, err, daddr, dwdata, we.
- FSM has three states: IDLE -> ACCESS -> RESP -> IDLE. Minimum 3 cycles per transaction; no pipelining.
- IDLE arbitration:
  - Only m0_req: grant 0. Only m1_req: grant 1.
  - Both: grant the requester != last_grant.
  - On grant, latch wr/size/unsigned/addr/wdata, set last_grant=grant, go to ACCESS.
- ACCESS memory drive:
  - daddr = latched addr.
  - Store: we/dwdata by size:
    - byte: we = 4'b0001 << addr[1:0], dwdata = {4{wdata[7:0]}}
    - half: we = 4'b0011 << {addr[1],1'b0}, dwdata = {2{wdata[15:0]}}
    - word: we = 4'b1111, dwdata = wdata
  - Load: we = 0. At the ACCESS->RESP edge, capture drdata >> (8*addr[1:0]); for half use addr[1] only. Extend from bit 7/15 per unsigned; word is unextended.
  - we, daddr and dwdata are nonzero only in ACCESS, so the memory writes exactly once at the ACCESS->RESP edge.
- RESP: assert ack of the granted requester for exactly one cycle, with rdata (loads; 0 for stores) and err. Always return to IDLE. req is ignored in RESP.
- A req still high in the IDLE cycle after ack is a new transaction.
- The non-granted requester waits with ack=0. It is granted in the next IDLE if still requesting, so no starvation (max wait = one transaction).
- Requester changing fields mid-transaction has no effect (latched at grant).
- Default (macro undefined):
  - Misalignment is silently aligned: half ignores addr[0]; word ignores addr[1:0].
  - Size 11 is treated as word.
  - err is always 0.

Optional Feature:
- Macro DMEM_ARB_MISALIGN_TRAP_EN.
- Defined: an access with size 11, half with addr[0]=1, or word with addr[1:0]!=0 is a fault:
  - ACCESS drives we=0 (no write).
  - RESP gives ack=1, err=1, rdata=0.
  - FSM timing is unchanged.
- Undefined: default alignment behaviour above; err ports tied 0.

Test Plan:
- Reset asserted mid-ACCESS of a store -> we=0 immediately, ack never pulses, state IDLE. Memory location unchanged (no store edge occurs).
- m0 byte store addr 0x05 data 0x000000AB -> ACCESS shows we=4'b0010, dwdata=0xABABABAB. m0_ack in 3rd cycle after req, rdata 0.
- m0 loads addr 0x05, unsigned=0 then unsigned=1 -> m0_rdata 0xFFFFFFAB then 0x000000AB. Half store 0x1234 at 0x06 -> we=4'b1100, dwdata=0x12341234.
- m0_req and m1_req both held high from reset -> grant order m0, m1, m0, m1. Each ack 3 cycles apart; the other ack stays 0.
- With macro: m1 word load addr 0x02 -> we=0, m1_ack=1, m1_err=1, m1_rdata=0. Without macro: same access reads word at 0x00, err=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin two-requester front end for the single-ported byte-lane data memory.
// Optional DMEM_ARB_MISALIGN_TRAP_EN: misaligned or size-11 accesses fault instead of being aligned.
module dmem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter bit RR_INIT = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [1:0]        m0_size,
    input  logic              m0_unsigned,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_ack,
    output logic [31:0]       m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [1:0]        m1_size,
    input  logic              m1_unsigned,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_ack,
    output logic [31:0]       m1_rdata,
    output logic              m1_err,
    output logic [ADDR_W-1:0] daddr,
    output logic [31:0]       dwdata,
    output logic [3:0]        we,
    input  logic [31:0]       drdata,
    output logic [1:0]        o_state
);

    // Requester handshake: mN_req is a level held with all fields stable until the
    // one-cycle mN_ack pulse; fields are latched at grant, so later changes are ignored.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_RESP = 2'd2} state_t;

    state_t            r_state;
    logic              r_last;
    logic              r_gnt;
    logic              r_wr;
    logic [1:0]        r_size;
    logic              r_uns;
    logic [1:0]        r_alo;
    logic              r_fault;
    logic [ADDR_W-1:0] r_daddr;
    logic [31:0]       r_dwdata;
    logic [3:0]        r_we;
    logic              r_ack0, r_ack1, r_err0, r_err1;
    logic [31:0]       r_rdata0, r_rdata1;

    logic              w_grant;
    logic              w_wr;
    logic [1:0]        w_size;
    logic              w_uns;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0]       w_wdata;
    logic              w_fault;
    logic [3:0]        w_we;
    logic [31:0]       w_dwdata;
    logic [31:0]       w_sh;
    logic [31:0]       w_ld;

    // Contention goes to whoever did not win last time.
    assign w_grant = (m0_req && m1_req) ? ~r_last : m1_req;
    assign w_wr    = w_grant ? m1_wr       : m0_wr;
    assign w_size  = w_grant ? m1_size     : m0_size;
    assign w_uns   = w_grant ? m1_unsigned : m0_unsigned;
    assign w_addr  = w_grant ? m1_addr     : m0_addr;
    assign w_wdata = w_grant ? m1_wdata    : m0_wdata;

`ifdef DMEM_ARB_MISALIGN_TRAP_EN
    assign w_fault = (w_size == 2'b11) ||
                     ((w_size == 2'b01) && w_addr[0]) ||
                     ((w_size == 2'b10) && (w_addr[1:0] != 2'b00));
`else
    assign w_fault = 1'b0;
`endif

    always_comb begin
        w_we     = 4'b0000;
        w_dwdata = '0;
        case (w_size)
            2'b00: begin
                w_we     = 4'b0001 << w_addr[1:0];
                w_dwdata = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                w_we     = 4'b0011 << {w_addr[1], 1'b0};
                w_dwdata = {2{w_wdata[15:0]}};
            end
            default: begin
                w_we     = 4'b1111;
                w_dwdata = w_wdata;
            end
        endcase
        if (!w_wr || w_fault) begin
            w_we     = 4'b0000;
            w_dwdata = '0;
        end
    end

    always_comb begin
        w_sh = drdata;
        w_ld = '0;
        case (r_size)
            2'b00:   w_sh = drdata >> {r_alo, 3'b000};
            2'b01:   w_sh = drdata >> {r_alo[1], 4'b0000};
            default: w_sh = drdata;
        endcase
        case (r_size)
            2'b00:   w_ld = r_uns ? {24'h0, w_sh[7:0]}  : {{24{w_sh[7]}}, w_sh[7:0]};
            2'b01:   w_ld = r_uns ? {16'h0, w_sh[15:0]} : {{16{w_sh[15]}}, w_sh[15:0]};
            default: w_ld = w_sh;
        endcase
        if (r_wr || r_fault) w_ld = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_last   <= RR_INIT;
            r_gnt    <= 1'b0;
            r_wr     <= 1'b0;
            r_size   <= 2'b00;
            r_uns    <= 1'b0;
            r_alo    <= 2'b00;
            r_fault  <= 1'b0;
            r_daddr  <= '0;
            r_dwdata <= '0;
            r_we     <= 4'b0000;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_err0   <= 1'b0;
            r_err1   <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (m0_req || m1_req) begin
                        r_gnt    <= w_grant;
                        r_last   <= w_grant;
                        r_wr     <= w_wr;
                        r_size   <= w_size;
                        r_uns    <= w_uns;
                        r_alo    <= w_addr[1:0];
                        r_fault  <= w_fault;
                        r_daddr  <= w_addr;
                        r_dwdata <= w_dwdata;
                        r_we     <= w_we;
                        r_state  <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // Memory sees we for exactly this one cycle; load data is captured here.
                    r_ack0   <= ~r_gnt;
                    r_ack1   <= r_gnt;
                    r_err0   <= ~r_gnt & r_fault;
                    r_err1   <= r_gnt & r_fault;
                    r_rdata0 <= r_gnt ? 32'h0 : w_ld;
                    r_rdata1 <= r_gnt ? w_ld : 32'h0;
                    r_daddr  <= '0;
                    r_dwdata <= '0;
                    r_we     <= 4'b0000;
                    r_state  <= S_RESP;
                end
                default: begin
                    r_ack0   <= 1'b0;
                    r_ack1   <= 1'b0;
                    r_err0   <= 1'b0;
                    r_err1   <= 1'b0;
                    r_rdata0 <= '0;
                    r_rdata1 <= '0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign m0_ack   = r_ack0;
    assign m1_ack   = r_ack1;
    assign m0_rdata = r_rdata0;
    assign m1_rdata = r_rdata1;
    assign m0_err   = r_err0;
    assign m1_err   = r_err1;
    assign daddr    = r_daddr;
    assign dwdata   = r_dwdata;
    assign we       = r_we;
    assign o_state  = r_state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 64-byte byte-lane memory model.
// Expectations follow the DMEM_ARB_MISALIGN_TRAP_EN build setting.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_wr, m0_unsigned, m1_req, m1_wr, m1_unsigned;
  logic [1:0]  m0_size, m1_size;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] daddr, dwdata, drdata;
  logic [3:0]  we;
  logic [1:0]  o_state;

  logic [7:0]  mem [0:63];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .RR_INIT(1'b1)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_unsigned(m0_unsigned),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_unsigned(m1_unsigned),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .daddr(daddr), .dwdata(dwdata), .we(we), .drdata(drdata), .o_state(o_state)
  );

  // Memory model: combinational word read, byte-lane write on posedge.
  logic [5:0] mem_base;
  assign mem_base = {daddr[5:2], 2'b00};
  assign drdata = {mem[mem_base + 6'd3], mem[mem_base + 6'd2], mem[mem_base + 6'd1], mem[mem_base]};
  always @(posedge clk) begin
    for (int l = 0; l < 4; l++)
      if (we[l]) mem[mem_base + 6'(l)] <= dwdata[8*l +: 8];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One transaction on a port; reports ack data, the we/dwdata seen while driven, and latency.
  task automatic txn(input int port, input logic wr, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err, output logic [3:0] we_seen,
                     output logic [31:0] dw_seen, output int lat);
    logic got;
    logic other;
    got = 1'b0; other = 1'b0; rdata = '0; err = 1'b0; we_seen = '0; dw_seen = '0; lat = 0;
    if (port == 0) begin
      m0_wr = wr; m0_size = size; m0_unsigned = uns; m0_addr = addr; m0_wdata = wdata; m0_req = 1'b1;
    end else begin
      m1_wr = wr; m1_size = size; m1_unsigned = uns; m1_addr = addr; m1_wdata = wdata; m1_req = 1'b1;
    end
    for (int i = 1; i <= 10 && !got; i++) begin
      @(posedge clk); #1;
      if (we != 4'b0000) begin
        we_seen = we;
        dw_seen = dwdata;
      end
      if (port == 0 ? m1_ack : m0_ack) other = 1'b1;
      if (port == 0 ? m0_ack : m1_ack) begin
        got = 1'b1;
        lat = i;
        rdata = (port == 0) ? m0_rdata : m1_rdata;
        err = (port == 0) ? m0_err : m1_err;
      end
    end
    check("ack_seen", {31'b0, got}, 32'd1);
    check("other_ack", {31'b0, other}, 32'd0);
    m0_req = 1'b0;
    m1_req = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [31:0] rd, dw;
  logic        er;
  logic [3:0]  ws;
  int          lat;
  int          ack_port [4];
  int          ack_cyc [4];
  int          n_ack;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    reset = 1'b1;
    m0_req = 0; m0_wr = 0; m0_size = 0; m0_unsigned = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_wr = 0; m1_size = 0; m1_unsigned = 0; m1_addr = 0; m1_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", {30'b0, o_state}, 32'd0);
    check("rst_we", {28'b0, we}, 32'd0);
    check("rst_daddr", daddr, 32'd0);
    check("rst_dwdata", dwdata, 32'd0);
    check("rst_acks", {30'b0, m0_ack, m1_ack}, 32'd0);
    check("rst_rdata", m0_rdata | m1_rdata, 32'd0);
    check("rst_err", {30'b0, m0_err, m1_err}, 32'd0);
    reset = 1'b0;

    // Reset in the middle of a word store: no write, no ack.
    @(posedge clk); #1;
    m0_wr = 1; m0_size = 2'b10; m0_addr = 32'h20; m0_wdata = 32'h55555555; m0_req = 1;
    @(posedge clk); #1;
    check("mid_we_before", {28'b0, we}, 32'hF);
    reset = 1'b1;
    #1;
    check("mid_we_after", {28'b0, we}, 32'd0);
    check("mid_state", {30'b0, o_state}, 32'd0);
    m0_req = 0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_no_ack", {31'b0, m0_ack}, 32'd0);
    reset = 1'b0;
    check("mid_mem", {24'b0, mem[32]}, 32'h20);
    @(posedge clk); #1;

    // Byte store 0xAB at 0x05.
    txn(0, 1, 2'b00, 0, 32'h05, 32'h000000AB, rd, er, ws, dw, lat);
    check("bst_we", {28'b0, ws}, 32'h2);
    check("bst_dw", dw, 32'hABABABAB);
    check("bst_lat", lat, 2);
    check("bst_rdata", rd, 32'd0);
    check("bst_mem", {24'b0, mem[5]}, 32'hAB);

    txn(0, 0, 2'b00, 0, 32'h05, 32'h0, rd, er, ws, dw, lat);
    check("lb_signed", rd, 32'hFFFFFFAB);
    check("lb_err", {31'b0, er}, 32'd0);
    txn(0, 0, 2'b00, 1, 32'h05, 32'h0, rd, er, ws, dw, lat);
    check("lb_unsigned", rd, 32'h000000AB);

    txn(0, 1, 2'b01, 0, 32'h06, 32'h00001234, rd, er, ws, dw, lat);
    check("hst_we", {28'b0, ws}, 32'hC);
    check("hst_dw", dw, 32'h12341234);
    txn(1, 0, 2'b10, 0, 32'h04, 32'h0, rd, er, ws, dw, lat);
    check("lw_04", rd, 32'h1234AB04);

    txn(1, 1, 2'b01, 0, 32'h08, 32'h00008001, rd, er, ws, dw, lat);
    check("hst8_we", {28'b0, ws}, 32'h3);
    txn(1, 0, 2'b01, 0, 32'h08, 32'h0, rd, er, ws, dw, lat);
    check("lh_signed", rd, 32'hFFFF8001);
    txn(1, 0, 2'b01, 1, 32'h08, 32'h0, rd, er, ws, dw, lat);
    check("lh_unsigned", rd, 32'h00008001);

    txn(0, 1, 2'b00, 0, 32'h0B, 32'hFFFFFF7F, rd, er, ws, dw, lat);
    check("bst_lane3_we", {28'b0, ws}, 32'h8);
    check("bst_lane3_dw", dw, 32'h7F7F7F7F);
    txn(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, rd, er, ws, dw, lat);
    check("wst_we", {28'b0, ws}, 32'hF);
    check("wst_dw", dw, 32'hDEADBEEF);
    txn(0, 0, 2'b10, 0, 32'h10, 32'h0, rd, er, ws, dw, lat);
    check("lw_10", rd, 32'hDEADBEEF);
    check("lw_lat", lat, 2);

    // Misaligned and reserved-size accesses.
    txn(1, 0, 2'b10, 0, 32'h02, 32'h0, rd, er, ws, dw, lat);
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
    check("mis_lw_rdata", rd, 32'd0);
    check("mis_lw_err", {31'b0, er}, 32'd1);
`else
    check("mis_lw_rdata", rd, 32'h03020100);
    check("mis_lw_err", {31'b0, er}, 32'd0);
`endif
    check("mis_lw_we", {28'b0, ws}, 32'd0);
    check("mis_lw_lat", lat, 2);

    txn(0, 1, 2'b01, 0, 32'h0D, 32'h0000BEEF, rd, er, ws, dw, lat);
    txn(0, 0, 2'b10, 0, 32'h0C, 32'h0, rd, er, ws, dw, lat);
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
    check("mis_hst_mem", rd, 32'h0F0E0D0C);
`else
    check("mis_hst_mem", rd, 32'h0F0EBEEF);
`endif

    txn(1, 0, 2'b11, 0, 32'h10, 32'h0, rd, er, ws, dw, lat);
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
    check("sz11_rdata", rd, 32'd0);
    check("sz11_err", {31'b0, er}, 32'd1);
`else
    check("sz11_rdata", rd, 32'hDEADBEEF);
    check("sz11_err", {31'b0, er}, 32'd0);
`endif

    // Both requesters held high from reset: strict alternation, one ack every 3 cycles.
    reset = 1'b1;
    m0_wr = 0; m0_size = 2'b10; m0_unsigned = 0; m0_addr = 32'h10; m0_req = 1;
    m1_wr = 0; m1_size = 2'b10; m1_unsigned = 0; m1_addr = 32'h04; m1_req = 1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_ack = 0;
    for (int c = 1; c <= 20 && n_ack < 4; c++) begin
      @(posedge clk); #1;
      if (m0_ack && m1_ack) check("rr_both_ack", 32'd1, 32'd0);
      else if (m0_ack || m1_ack) begin
        ack_port[n_ack] = m1_ack ? 1 : 0;
        ack_cyc[n_ack] = c;
        if (m0_ack) check("rr_m0_rdata", m0_rdata, 32'hDEADBEEF);
        else check("rr_m1_rdata", m1_rdata, 32'h1234AB04);
        n_ack++;
      end
    end
    m0_req = 0;
    m1_req = 0;
    check("rr_count", n_ack, 4);
    for (int k = 0; k < n_ack; k++) begin
      check("rr_order", ack_port[k], k % 2);
      if (k > 0) check("rr_gap", ack_cyc[k] - ack_cyc[k-1], 3);
    end
    check("rr_first_cyc", (n_ack > 0) ? ack_cyc[0] : 0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
